// File: rtl/hamming_secded_codec.sv
// hamming_secded_codec
//   SECDED extended-Hamming codec with independent encode and decode paths.
//   Codeword layout: bit i is Hamming position i. The power-of-two positions
//   hold parity. Data fills the remaining positions LSB first. Bit 0 is the
//   overall even parity over the whole word.
//
//   Ports
//     clk, arstn            clock (rising edge), asynchronous active-low reset
//     enc_valid_i/data_i    encoder input word
//     enc_valid_o/code_o    encoded word, 1-cycle latency, held when idle
//     dec_valid_i/code_i    decoder input codeword
//     dec_valid_o           decoder result valid, 2-cycle latency
//     dec_data_o            decoded data, corrected when CORRECT_EN != 0
//     dec_single_o          single-bit error seen
//     dec_double_o          uncorrectable error seen
//     dec_syndrome_o        Hamming syndrome of the received word
//     cnt_clr_i             synchronous clear of both error counters
//     cnt_single_o/double_o saturating counts of flagged decoder words
module hamming_secded_codec #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned CORRECT_EN = 1,
  // Smallest P with 2**P >= DATA_W+P+1, valid for DATA_W up to 502
  localparam int unsigned P = (DATA_W <= 4)   ? 3 :
                              (DATA_W <= 11)  ? 4 :
                              (DATA_W <= 26)  ? 5 :
                              (DATA_W <= 57)  ? 6 :
                              (DATA_W <= 120) ? 7 :
                              (DATA_W <= 247) ? 8 : 9,
  localparam int unsigned N = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              enc_valid_i,
  input  logic [DATA_W-1:0] enc_data_i,
  output logic              enc_valid_o,
  output logic [N-1:0]      enc_code_o,
  input  logic              dec_valid_i,
  input  logic [N-1:0]      dec_code_i,
  output logic              dec_valid_o,
  output logic [DATA_W-1:0] dec_data_o,
  output logic              dec_single_o,
  output logic              dec_double_o,
  output logic [P-1:0]      dec_syndrome_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  cnt_single_o,
  output logic [CNT_W-1:0]  cnt_double_o
);

  localparam logic [P-1:0] MAX_POS = P'(N - 1);

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Codeword position of data bit j
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned n;
    n        = 0;
    data_pos = 0;
    for (int unsigned i = 1; i < N; i++) begin
      if (!is_pow2(i)) begin
        if (n == j) data_pos = i;
        n++;
      end
    end
  endfunction

  // Data positions covered by the parity bit at position 2**k
  function automatic logic [N-1:0] par_mask(input int unsigned k);
    par_mask = '0;
    for (int unsigned i = 1; i < N; i++) begin
      if (!is_pow2(i) && (((i >> k) & 1) != 0)) par_mask[i] = 1'b1;
    end
  endfunction

  // ---------------- encoder ----------------
  logic [N-1:0] enc_map;
  logic [N-1:0] enc_word;
  logic         enc_pbit;
  logic         enc_ovr;

  always_comb begin
    enc_map = '0;
    for (int unsigned j = 0; j < DATA_W; j++) enc_map[data_pos(j)] = enc_data_i[j];
  end

  always_comb begin
    enc_word = enc_map;
    enc_ovr  = ^enc_map;
    enc_pbit = 1'b0;
    for (int unsigned k = 0; k < P; k++) begin
      enc_pbit            = ^(enc_map & par_mask(k));
      enc_word[1 << k]    = enc_pbit;
      enc_ovr             = enc_ovr ^ enc_pbit;
    end
    enc_word[0] = enc_ovr;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      enc_valid_o <= 1'b0;
      enc_code_o  <= '0;
    end else begin
      enc_valid_o <= enc_valid_i;
      if (enc_valid_i) enc_code_o <= enc_word;
    end
  end

  // ---------------- decoder stage 1 ----------------
  logic [P-1:0] syn_c;
  logic         s1_valid;
  logic [N-1:0] s1_code;
  logic [P-1:0] s1_syn;
  logic         s1_par;

  always_comb begin
    syn_c = '0;
    for (int unsigned i = 1; i < N; i++) begin
      if (dec_code_i[i]) syn_c = syn_c ^ P'(i);
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else begin
      s1_valid <= dec_valid_i;
      if (dec_valid_i) begin
        s1_code <= dec_code_i;
        s1_syn  <= syn_c;
        s1_par  <= ^dec_code_i;
      end
    end
  end

  // ---------------- decoder stage 2 ----------------
  logic [N-1:0]      dec_fixed;
  logic [DATA_W-1:0] dec_data_c;
  logic              single_c;
  logic              double_c;

  always_comb begin
    dec_fixed = s1_code;
    single_c  = 1'b0;
    double_c  = 1'b0;
    if (s1_par) begin
      if (s1_syn == '0) begin
        single_c = 1'b1;                 // overall parity bit itself flipped
      end else if (s1_syn <= MAX_POS) begin
        single_c = 1'b1;
        if (CORRECT_EN != 0) dec_fixed[s1_syn] = ~s1_code[s1_syn];
      end else begin
        double_c = 1'b1;                 // syndrome points past the word
      end
    end else if (s1_syn != '0) begin
      double_c = 1'b1;
    end
  end

  always_comb begin
    dec_data_c = '0;
    for (int unsigned j = 0; j < DATA_W; j++) dec_data_c[j] = dec_fixed[data_pos(j)];
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      dec_valid_o    <= 1'b0;
      dec_data_o     <= '0;
      dec_single_o   <= 1'b0;
      dec_double_o   <= 1'b0;
      dec_syndrome_o <= '0;
    end else begin
      dec_valid_o  <= s1_valid;
      dec_single_o <= s1_valid & single_c;
      dec_double_o <= s1_valid & double_c;
      if (s1_valid) begin
        dec_data_o     <= dec_data_c;
        dec_syndrome_o <= s1_syn;
      end
    end
  end

  // ---------------- error counters ----------------
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_single_o <= '0;
      cnt_double_o <= '0;
    end else if (cnt_clr_i) begin
      cnt_single_o <= '0;
      cnt_double_o <= '0;
    end else begin
      if (dec_valid_o && dec_single_o && (cnt_single_o != '1))
        cnt_single_o <= cnt_single_o + CNT_W'(1);
      if (dec_valid_o && dec_double_o && (cnt_double_o != '1))
        cnt_double_o <= cnt_double_o + CNT_W'(1);
    end
  end

endmodule
